// File: rtl/fp_round_encoder_pkg.sv
// fp_round_encoder_pkg
//   Shared types and constants for the FPU round/pack stage:
//   rounding-mode enum, FP32/FP64 format constants, canonical quiet NaNs,
//   the exception-flag struct, and small helpers for mode decode and
//   overflow result selection.
package fp_round_encoder_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rnd_mode_e;

  localparam int FP64_EMAX   = 2047;
  localparam int FP32_EMAX   = 255;
  localparam int FP64_BIAS   = 1023;
  localparam int FP32_BIAS   = 127;
  localparam int FP64_FRAC_W = 52;
  localparam int FP32_FRAC_W = 23;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Packs to {overflow, underflow, inexact}.
  typedef struct packed {
    logic ovf;
    logic unf;
    logic nx;
  } flags_t;

  // Reserved encodings 5..7 fall back to round-to-nearest-even.
  function automatic rnd_mode_e to_rnd_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

  // On overflow, modes that round away from zero in the result's direction
  // produce infinity; the rest saturate to the largest finite value.
  function automatic logic ovf_to_inf(input rnd_mode_e mode, input logic sign);
    case (mode)
      RM_RNE, RM_RMM: return 1'b1;
      RM_RUP:         return !sign;
      RM_RDN:         return sign;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_round_encoder_if.sv
// fp_round_encoder_if
//   Input/output beat bundle for the round/pack stage.
//   Input side : in_valid/in_ready handshake, sign_in, exponent_in (signed,
//                biased in target format), mantissa_in {hidden, frac52, G, R, S},
//                is_double_precision, rnd_mode, is_nan/is_inf/is_zero.
//   Output side: out_valid/out_ready handshake, fp_out (packed), flags_out.
//   master = producer/consumer around the block, slave = the block itself.
interface fp_round_encoder_if #(
  parameter int EXP_W = 13
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_in;
  logic signed [EXP_W-1:0] exponent_in;
  logic [55:0]             mantissa_in;
  logic                    is_double_precision;
  logic [2:0]              rnd_mode;
  logic                    is_nan;
  logic                    is_inf;
  logic                    is_zero;
  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             fp_out;
  logic [2:0]              flags_out;

  modport master (
    output in_valid, sign_in, exponent_in, mantissa_in, is_double_precision,
           rnd_mode, is_nan, is_inf, is_zero, out_ready,
    input  in_ready, out_valid, fp_out, flags_out
  );

  modport slave (
    input  in_valid, sign_in, exponent_in, mantissa_in, is_double_precision,
           rnd_mode, is_nan, is_inf, is_zero, out_ready,
    output in_ready, out_valid, fp_out, flags_out
  );
endinterface

// File: rtl/fp_round_encoder_decide.sv
// fp_round_decide
//   Combinational rounding decision.
//   sign, lsb, g, r, s : result sign, fraction LSB, guard/round/sticky bits
//   rnd_mode           : decoded rounding mode
//   inc                : add one ulp to the truncated significand
//   inexact            : any discarded bit was set
module fp_round_decide
  import fp_round_encoder_pkg::*;
(
  input  logic      sign,
  input  logic      lsb,
  input  logic      g,
  input  logic      r,
  input  logic      s,
  input  rnd_mode_e rnd_mode,
  output logic      inc,
  output logic      inexact
);

  always_comb begin
    inexact = g | r | s;
    inc     = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc = g & (r | s | lsb);   // ties go to even lsb
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = !sign & (g | r | s);
      RM_RMM:  inc = g;                   // ties away from zero
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_round_encoder.sv
// fp_round_encoder
//   Final FPU stage: rounds an unpacked result and packs it to FP64 or FP32.
//   Two-stage pipeline:
//     S1: slice fraction/GRS per format, round decision, significand increment
//     S2: carry renormalise, underflow/overflow/special handling, pack
//   Ports: clk, rst (sync, active high), bus (fp_round_encoder_if.slave).
//   Flow control: one global enable; a held output stalls every stage.
//   Parameters: EXP_W exponent width, NAN_BOX selects FP32 upper word fill.
module fp_round_encoder
  import fp_round_encoder_pkg::*;
#(
  parameter int EXP_W   = 13,
  parameter bit NAN_BOX = 1'b0
) (
  input logic              clk,
  input logic              rst,
  fp_round_encoder_if.slave bus
);

  localparam int          STAGES = 2;
  localparam logic [31:0] UPPER  = NAN_BOX ? 32'hFFFF_FFFF : 32'h0;

  // State carried from S1 to S2. The fraction is kept at FP64 width; FP32
  // beats use the low 23 bits.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             carry;
    logic [51:0]      frac;
    logic             dp;
    rnd_mode_e        mode;
    logic             nx;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  logic [63:0]     res, fp_q;
  flags_t          fl, fl_q;

  // Stall only when the output holds a beat nobody takes.
  assign en           = !(vld_pipe[STAGES] && !bus.out_ready);
  assign bus.in_ready = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.fp_out    = fp_q;
  assign bus.flags_out = fl_q;

  // ---------------- S1: round decision and increment ----------------
  rnd_mode_e   mode_in;
  logic        lsb, g, r, s, inc, nx;
  logic [53:0] sum64;
  logic [24:0] sum32;

  assign mode_in = to_rnd_mode(bus.rnd_mode);

  always_comb begin
    if (bus.is_double_precision) begin
      lsb = bus.mantissa_in[3];
      g   = bus.mantissa_in[2];
      r   = bus.mantissa_in[1];
      s   = bus.mantissa_in[0];
    end else begin
      lsb = bus.mantissa_in[32];
      g   = bus.mantissa_in[31];
      r   = bus.mantissa_in[30];
      s   = |bus.mantissa_in[29:0];
    end
  end

  fp_round_decide u_decide (
    .sign     (bus.sign_in),
    .lsb      (lsb),
    .g        (g),
    .r        (r),
    .s        (s),
    .rnd_mode (mode_in),
    .inc      (inc),
    .inexact  (nx)
  );

  // {carry, hidden, fraction}: carry set only when an all-ones fraction
  // rounds up, leaving hidden and fraction zero.
  assign sum64 = {2'b01, bus.mantissa_in[54:3]} + 54'(inc);
  assign sum32 = {2'b01, bus.mantissa_in[54:32]} + 25'(inc);

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = bus.sign_in;
    s1_d.exp     = bus.exponent_in;
    s1_d.dp      = bus.is_double_precision;
    s1_d.mode    = mode_in;
    s1_d.nx      = nx;
    s1_d.is_nan  = bus.is_nan;
    s1_d.is_inf  = bus.is_inf;
    s1_d.is_zero = bus.is_zero;
    if (bus.is_double_precision) begin
      s1_d.carry = sum64[53];
      s1_d.frac  = sum64[51:0];
    end else begin
      s1_d.carry = sum32[24];
      s1_d.frac  = {29'b0, sum32[22:0]};
    end
  end

  // ---------------- S2: renormalise, range check, pack ----------------
  logic signed [EXP_W:0] exp_pre, exp_rnd, e_max;
  logic [51:0]           frac_f;

  function automatic logic [63:0] pack(input logic dp, input logic sign,
                                       input logic [10:0] e, input logic [51:0] f);
    if (dp) return {sign, e, f};
    return {UPPER, sign, e[7:0], f[22:0]};
  endfunction

  // One extra bit keeps the carry increment from wrapping the exponent.
  assign exp_pre = $signed({s1_q.exp[EXP_W-1], s1_q.exp});
  assign exp_rnd = exp_pre + $signed({{EXP_W{1'b0}}, s1_q.carry});
  assign e_max   = s1_q.dp ? (EXP_W+1)'(FP64_EMAX) : (EXP_W+1)'(FP32_EMAX);
  assign frac_f  = s1_q.carry ? '0 : s1_q.frac;

  always_comb begin
    res = '0;
    fl  = '0;
    if (s1_q.is_nan) begin
      res = s1_q.dp ? FP64_QNAN : {UPPER, FP32_QNAN};
    end else if (s1_q.is_inf) begin
      res = pack(s1_q.dp, s1_q.sign, 11'h7FF, '0);
    end else if (s1_q.is_zero) begin
      res = pack(s1_q.dp, s1_q.sign, 11'h000, '0);
    end else if (exp_pre <= 0) begin
      // Flush-to-zero: decided on the pre-rounding exponent.
      res    = pack(s1_q.dp, s1_q.sign, 11'h000, '0);
      fl.unf = 1'b1;
      fl.nx  = 1'b1;
    end else if (exp_rnd >= e_max) begin
      fl.ovf = 1'b1;
      fl.nx  = 1'b1;
      // 11'h7FE / all-ones fraction truncates to 254 / 23 ones for FP32.
      res = ovf_to_inf(s1_q.mode, s1_q.sign) ? pack(s1_q.dp, s1_q.sign, 11'h7FF, '0)
                                              : pack(s1_q.dp, s1_q.sign, 11'h7FE, '1);
    end else begin
      res   = pack(s1_q.dp, s1_q.sign, exp_rnd[10:0], frac_f);
      fl.nx = s1_q.nx;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      fp_q     <= '0;
      fl_q     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      // Data only moves with a valid beat so idle cycles leave outputs quiet.
      if (bus.in_valid) s1_q <= s1_d;
      if (vld_pipe[1]) begin
        fp_q <= res;
        fl_q <= fl;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_encoder.sv
module tb_fp_round_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_round_encoder_if #(.EXP_W(13)) bus ();

  fp_round_encoder #(.EXP_W(13), .NAN_BOX(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] fp;
    logic [2:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Scoreboard: pop and compare on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_output: observed=%h expected=none", bus.fp_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fp_out", bus.fp_out, e.fp);
        chk("flags_out", {61'b0, bus.flags_out}, {61'b0, e.fl});
      end
    end
  end

  function automatic logic [55:0] m64(input logic [51:0] f, input logic [2:0] grs);
    return {1'b1, f, grs};
  endfunction

  function automatic logic [55:0] m32(input logic [22:0] f, input logic g, input logic r,
                                      input logic [29:0] low);
    return {1'b1, f, g, r, low};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  // spc = {is_nan, is_inf, is_zero}.
  task automatic send(input logic s, input logic signed [12:0] e, input logic [55:0] m,
                      input logic dp, input logic [2:0] md, input logic [2:0] spc,
                      input logic [63:0] efp, input logic [2:0] efl, input bit push);
    bit acc = 0;
    int n = 0;
    bus.sign_in             = s;
    bus.exponent_in         = e;
    bus.mantissa_in         = m;
    bus.is_double_precision = dp;
    bus.rnd_mode            = md;
    {bus.is_nan, bus.is_inf, bus.is_zero} = spc;
    bus.in_valid            = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (acc)
    else begin
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 expected=1");
    end
    if (acc && push) exp_q.push_back('{efp, efl});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.sign_in = 1'b0;
    bus.exponent_in = '0;
    bus.mantissa_in = '0;
    bus.is_double_precision = 1'b0;
    bus.rnd_mode = '0;
    {bus.is_nan, bus.is_inf, bus.is_zero} = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_fp_out", bus.fp_out, 64'd0);
    chk("rst_flags", {61'b0, bus.flags_out}, 64'd0);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, streamed back to back.
    send(0, 1023, m64(52'h0, 3'b100), 1, 3'd0, 3'b000, 64'h3FF0_0000_0000_0000, 3'b001, 1);
    send(0, 1023, m64(52'h1, 3'b100), 1, 3'd0, 3'b000, 64'h3FF0_0000_0000_0002, 3'b001, 1);
    send(0, 1023, m64(52'h1, 3'b100), 1, 3'd7, 3'b000, 64'h3FF0_0000_0000_0002, 3'b001, 1);
    send(0, 1023, m64(52'h0, 3'b100), 1, 3'd4, 3'b000, 64'h3FF0_0000_0000_0001, 3'b001, 1);
    send(0, 1023, m64(52'h0, 3'b011), 1, 3'd2, 3'b000, 64'h3FF0_0000_0000_0000, 3'b001, 1);
    send(1, 1023, m64(52'h0, 3'b001), 1, 3'd3, 3'b000, 64'hBFF0_0000_0000_0000, 3'b001, 1);
    send(0, 1030, m64(52'hABCDE, 3'b000), 1, 3'd1, 3'b000, {1'b0, 11'd1030, 52'hABCDE}, 3'b000, 1);
    send(0, 127, m32(23'h7FFFFF, 1, 0, 30'h0), 0, 3'd0, 3'b000, 64'h0000_0000_4000_0000, 3'b001, 1);
    send(0, 127, m32(23'h0, 0, 0, 30'h1), 0, 3'd3, 3'b000, 64'h0000_0000_3F80_0001, 3'b001, 1);
    send(1, 130, m32(23'h400000, 0, 0, 30'h0), 0, 3'd0, 3'b000, 64'h0000_0000_C140_0000, 3'b000, 1);
    send(0, 2047, m64(52'h0, 3'b000), 1, 3'd0, 3'b000, 64'h7FF0_0000_0000_0000, 3'b101, 1);
    send(0, 2047, m64(52'h0, 3'b000), 1, 3'd1, 3'b000, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101, 1);
    send(1, 2047, m64(52'h0, 3'b000), 1, 3'd2, 3'b000, 64'hFFF0_0000_0000_0000, 3'b101, 1);
    send(1, 2047, m64(52'h0, 3'b000), 1, 3'd3, 3'b000, 64'hFFEF_FFFF_FFFF_FFFF, 3'b101, 1);
    send(0, 2046, m64('1, 3'b100), 1, 3'd0, 3'b000, 64'h7FF0_0000_0000_0000, 3'b101, 1);
    send(0, 255, m32(23'h0, 0, 0, 30'h0), 0, 3'd0, 3'b000, 64'h0000_0000_7F80_0000, 3'b101, 1);
    send(0, 255, m32(23'h0, 0, 0, 30'h0), 0, 3'd1, 3'b000, 64'h0000_0000_7F7F_FFFF, 3'b101, 1);
    send(1, 0, m64(52'h0, 3'b000), 1, 3'd0, 3'b000, 64'h8000_0000_0000_0000, 3'b011, 1);
    send(0, -5, m64(52'h0, 3'b000), 1, 3'd0, 3'b000, 64'h0000_0000_0000_0000, 3'b011, 1);
    send(0, 1, m64(52'h0, 3'b000), 1, 3'd0, 3'b000, 64'h0010_0000_0000_0000, 3'b000, 1);
    send(1, 100, m64(52'h5, 3'b111), 0, 3'd0, 3'b111, 64'h0000_0000_7FC0_0000, 3'b000, 1);
    send(1, 100, m64(52'h5, 3'b111), 1, 3'd0, 3'b100, 64'h7FF8_0000_0000_0000, 3'b000, 1);
    send(1, 100, m64(52'h5, 3'b111), 1, 3'd0, 3'b011, 64'hFFF0_0000_0000_0000, 3'b000, 1);
    send(1, 2047, m64(52'h5, 3'b111), 0, 3'd0, 3'b001, 64'h0000_0000_8000_0000, 3'b000, 1);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: 8 beats with a 3-cycle output stall in the middle.
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [51:0] f;
          f = 52'(i * 32'h1357_9BDF);
          send(0, 13'(1000 + i), m64(f, 3'b000), 1, 3'd1, 3'b000,
               {1'b0, 11'(1000 + i), f}, 3'b000, 1);
        end
        c1 = cyc;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    bus.in_valid = 1'b0;
    chk("stream_cycles", 64'(c1 - c0), 64'd11);
    drain();

    // Reset with two beats in flight: neither may ever appear.
    send(0, 1023, m64(52'h1, 3'b000), 1, 3'd0, 3'b000, 64'h0, 3'b000, 0);
    send(0, 1024, m64(52'h2, 3'b000), 1, 3'd0, 3'b000, 64'h0, 3'b000, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("midrst_fp_out", bus.fp_out, 64'd0);
    chk("midrst_flags", {61'b0, bus.flags_out}, 64'd0);
    chk("midrst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {63'b0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(0, 1023, m64(52'h0, 3'b100), 1, 3'd0, 3'b000, 64'h3FF0_0000_0000_0000, 3'b001, 1);
    bus.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
